// File: rtl/ml_ahb_arb_pkg.sv
// Shared encodings and helpers for the AHB slave-port arbiter.
package ml_ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE = 2'b00,
        HTRANS_BUSY = 2'b01,
        HTRANS_NSEQ = 2'b10,
        HTRANS_SEQ  = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ARB_MODE_FIXED = 2'd0,
        ARB_MODE_RR    = 2'd1,
        ARB_MODE_WRR   = 2'd2
    } arb_mode_e;

    function automatic int unsigned f_clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) res++;
        return res;
    endfunction

endpackage

// File: rtl/ml_ahb_arb_pick.sv
// Combinational winner picker: starvation first, then lowest priority level,
// then owner precedence, then fixed or rotating tie-break.
module ml_ahb_arb_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    starve,
    input  logic [N*PW-1:0] prio,
    input  logic [IW-1:0]   rr_ptr,
    input  logic            use_rr,
    input  logic            owner_prec,
    input  logic [N-1:0]    owner_oh,
    output logic [N-1:0]    winner
);

    logic [N-1:0]  starve_req;
    logic [N-1:0]  cand;
    logic [PW-1:0] min_prio;

    always_comb begin
        starve_req = starve & req;
        min_prio   = '1;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && (prio[i*PW +: PW] < min_prio)) min_prio = prio[i*PW +: PW];
        end
        for (int i = 0; i < int'(N); i++) begin
            cand[i] = req[i] && (prio[i*PW +: PW] == min_prio);
        end
    end

    // Descending loops: the last hit is the lowest index / lowest rotation offset.
    always_comb begin
        winner = '0;
        if (|starve_req) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (starve_req[i]) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end else if (owner_prec && |(cand & owner_oh)) begin
            winner = owner_oh;
        end else if (!use_rr) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end else begin
            for (int off = int'(N) - 1; off >= 0; off--) begin
                if (cand[(int'(rr_ptr) + off) % int'(N)]) begin
                    winner = '0;
                    winner[(int'(rr_ptr) + off) % int'(N)] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ml_ahb_arb_port_gen.sv
// AHB slave-port arbiter: fixed / round-robin / weighted round-robin with burst and
// lock hold, deny capture and starvation escalation.
module ml_ahb_arb_port_gen
    import ml_ahb_arb_pkg::*;
#(
    parameter int unsigned NB_MASTER_PORT = 4,
    parameter int unsigned PRIO_WIDTH     = 2,
    parameter int unsigned WEIGHT_WIDTH   = 4,
    parameter int unsigned MAX_WAIT       = 64,
    localparam int unsigned OW            = f_clog2(NB_MASTER_PORT)
) (
    input  logic                                   hclk,
    input  logic                                   reset,
    input  logic [1:0]                             arb_mode,
    input  logic [NB_MASTER_PORT*PRIO_WIDTH-1:0]   priority_level,
    input  logic [NB_MASTER_PORT*WEIGHT_WIDTH-1:0] weight,
    input  logic [NB_MASTER_PORT-1:0]              mx_sel,
    input  logic [2*NB_MASTER_PORT-1:0]            mx_htrans,
    input  logic [NB_MASTER_PORT-1:0]              mx_hmastlock,
    input  logic                                   hready,
    output logic [NB_MASTER_PORT-1:0]              mx_arb_grant,
    output logic [OW-1:0]                          arb_owner,
    output logic                                   arb_owner_vld,
    output logic [NB_MASTER_PORT-1:0]              starve_flag
);

    localparam int unsigned N  = NB_MASTER_PORT;
    localparam int unsigned WW = WEIGHT_WIDTH;
    localparam int unsigned CW = f_clog2(MAX_WAIT + 1);

    logic [N-1:0]  grant_q, pend_q, pend_set, req, winner, owner_oh;
    logic [OW-1:0] rr_ptr_q, win_idx, grant_idx;
    logic [WW-1:0] credit_q, weight_k;
    logic [CW-1:0] wait_q [N];
    logic [1:0]    owner_htrans;
    logic          hold, new_own, owner_prec;

    assign req          = mx_sel | pend_q;
    assign owner_htrans = mx_htrans[2*int'(arb_owner) +: 2];
    assign hold = !hready || (arb_owner_vld && (owner_htrans == HTRANS_SEQ ||
                  owner_htrans == HTRANS_BUSY || mx_hmastlock[arb_owner]));
    assign owner_prec = (arb_mode == ARB_MODE_WRR) && arb_owner_vld && (credit_q != '0);

    always_comb begin
        owner_oh = '0;
        if (arb_owner_vld) owner_oh[arb_owner] = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            starve_flag[i] = (wait_q[i] == CW'(MAX_WAIT));
        end
    end

    ml_ahb_arb_pick #(
        .N  (N),
        .PW (PRIO_WIDTH),
        .IW (OW)
    ) u_pick (
        .req        (req),
        .starve     (starve_flag),
        .prio       (priority_level),
        .rr_ptr     (rr_ptr_q),
        .use_rr     (arb_mode != ARB_MODE_FIXED),
        .owner_prec (owner_prec),
        .owner_oh   (owner_oh),
        .winner     (winner)
    );

    always_comb begin
        if (reset)     mx_arb_grant = '0;
        else if (hold) mx_arb_grant = grant_q;
        else           mx_arb_grant = winner;
        win_idx   = '0;
        grant_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (winner[i])       win_idx   = OW'(i);
            if (mx_arb_grant[i]) grant_idx = OW'(i);
            pend_set[i] = mx_sel[i] && (mx_htrans[2*i +: 2] == HTRANS_NSEQ) && !mx_arb_grant[i];
        end
        weight_k = weight[int'(win_idx)*WW +: WW];
        new_own  = !hold && (|winner) && (!arb_owner_vld || (win_idx != arb_owner));
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            grant_q       <= '0;
            pend_q        <= '0;
            rr_ptr_q      <= '0;
            credit_q      <= '0;
            arb_owner     <= '0;
            arb_owner_vld <= 1'b0;
            for (int i = 0; i < int'(N); i++) wait_q[i] <= '0;
        end else begin
            if (hready) begin
                grant_q       <= mx_arb_grant;
                arb_owner     <= grant_idx;
                arb_owner_vld <= |mx_arb_grant;
            end
            // Clear wins over set for a master granted this cycle.
            pend_q <= (pend_q | pend_set) & ~mx_arb_grant;
            if (new_own) begin
                rr_ptr_q <= (win_idx == OW'(N - 1)) ? '0 : win_idx + 1'b1;
                credit_q <= (weight_k == '0) ? '0 : weight_k - 1'b1;
            end else if (!hold && arb_owner_vld && owner_htrans == HTRANS_NSEQ &&
                         credit_q != '0) begin
                credit_q <= credit_q - 1'b1;
            end
            for (int i = 0; i < int'(N); i++) begin
                if (mx_arb_grant[i] || !req[i])          wait_q[i] <= '0;
                else if (hready && !starve_flag[i])      wait_q[i] <= wait_q[i] + 1'b1;
            end
        end
    end

endmodule
